// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: sequential PC generation, credit-limited imem requests and an
// in-order prefetch queue feeding IF/ID. Optional perf counters are enabled by FETCH_PERF_EN.
module fetch_prefetch_queue #(
  parameter int unsigned       ADDR_W   = 7,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_stall,
  output logic [15:0]       perf_flush
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {StIdle, StFill, StStream, StFull, StDrain} state_e;

  logic [ADDR_W-1:0] fetch_pc_q, resp_pc_q;
  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, inflight_q, drop_q;
  logic [CNT_W-1:0]  count_d, inflight_d, drop_d;
  state_e            state_q, state_d;

  logic              issue, pop, push;
  logic [CNT_W:0]    occupancy;

  always_comb begin
    occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
    imem_req   = ~rst & ~redir_valid & (occupancy < (CNT_W + 1)'(DEPTH));
    imem_addr  = fetch_pc_q;
    issue      = imem_req & imem_gnt;
    pop        = out_valid & out_ready & ~redir_valid;
    // Words belonging to a squashed fetch stream are never written into the queue.
    push       = imem_rvalid & ~redir_valid & (drop_q == '0);
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(imem_rvalid);
    count_d    = redir_valid ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);

    if (redir_valid) begin
      drop_d = inflight_d;
    end else if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end else begin
      drop_d = drop_q;
    end

    // While draining the queue is always empty, so DRAIN takes precedence.
    if (drop_d != '0) begin
      state_d = StDrain;
    end else if ((count_d == '0) && (inflight_d == '0)) begin
      state_d = StIdle;
    end else if (count_d == CNT_W'(DEPTH)) begin
      state_d = StFull;
    end else if (count_d != '0) begin
      state_d = StStream;
    end else begin
      state_d = StFill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      state_q    <= StIdle;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
      if (redir_valid) begin
        fetch_pc_q <= redir_pc;
        resp_pc_q  <= redir_pc;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (issue) fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
        if (push) begin
          resp_pc_q <= resp_pc_q + ADDR_W'(1);
          wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  always_comb begin
    out_valid = (state_q == StStream) || (state_q == StFull);
    out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  end

`ifdef FETCH_PERF_EN
  logic [15:0]    perf_stall_q, perf_flush_q;
  logic           discard;
  logic [CNT_W:0] flush_inc;
  logic [16:0]    flush_sum;

  always_comb begin
    discard   = imem_rvalid & ~push;
    flush_inc = (redir_valid ? {1'b0, count_q} : '0) + (CNT_W + 1)'(discard);
    flush_sum = {1'b0, perf_flush_q} + 17'(flush_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
      perf_flush_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue: epoch-tagged memory model plus an expected-stream
// scoreboard checked by a negedge monitor. Perf counters are checked when FETCH_PERF_EN is set.
module tb_fetch_prefetch_queue;

  localparam int unsigned       ADDR_W   = 7;
  localparam int unsigned       DATA_W   = 32;
  localparam int unsigned       DEPTH    = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [15:0]       perf_stall;
  logic [15:0]       perf_flush;
`endif

  fetch_prefetch_queue #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       epoch;
  } req_t;

  entry_t            sb[$];    // words the decode stage must see, in order
  req_t              memq[$];  // requests accepted by the memory, oldest first
  int                checks = 0;
  int                errors = 0;
  int                pops = 0;
  logic [31:0]       epoch = 0;
  logic [ADDR_W-1:0] fetch_exp = RESET_PC;
  int                model_stall = 0;
  int                model_flush = 0;
  logic              after_rst = 1'b0;

  int                gnt_pct, ready_pct, rvalid_pct, redir_pct;
  logic              rst_req;
  logic              force_redir = 1'b0;
  logic [ADDR_W-1:0] force_pc;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT against the model, then advances the model by one cycle.
  always @(negedge clk) begin
    int   occupied;
    logic exp_valid;
    req_t r;
    if (rst) begin
      check("req_in_reset", 64'(imem_req), 64'(0));
      sb.delete();
      memq.delete();
      fetch_exp   = RESET_PC;
      epoch       = epoch + 1;
      model_stall = 0;
      model_flush = 0;
      after_rst   = 1'b1;
    end else begin
      if (after_rst) begin
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_pc", 64'(out_pc), 64'(0));
        check("reset_out_instr", 64'(out_instr), 64'(0));
        after_rst = 1'b0;
      end
`ifdef FETCH_PERF_EN
      check("perf_stall", 64'(perf_stall), 64'(model_stall));
      check("perf_flush", 64'(perf_flush), 64'(model_flush));
`endif
      occupied  = sb.size() + memq.size();
      exp_valid = (sb.size() != 0);
      check("imem_req", 64'(imem_req), 64'(!redir_valid && (occupied < int'(DEPTH))));
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      if (exp_valid) begin
        check("out_pc", 64'(out_pc), 64'(sb[0].pc));
        check("out_instr", 64'(out_instr), 64'(sb[0].instr));
        if (!out_ready && model_stall < 16'hFFFF) model_stall++;
        if (out_ready && !redir_valid) begin
          void'(sb.pop_front());
          pops++;
        end
      end
      if (imem_rvalid && memq.size() != 0) begin
        r = memq.pop_front();
        if (!redir_valid && r.epoch == epoch) begin
          sb.push_back('{pc: r.addr, instr: mem_word(r.addr)});
        end else begin
          model_flush++;
        end
      end
      if (imem_req && imem_gnt) begin
        check("imem_addr", 64'(imem_addr), 64'(fetch_exp));
        memq.push_back('{addr: fetch_exp, epoch: epoch});
        fetch_exp = fetch_exp + ADDR_W'(1);
      end
      if (redir_valid) begin
        model_flush += sb.size();
        sb.delete();
        epoch     = epoch + 1;
        fetch_exp = redir_pc;
      end
      if (model_flush > 16'hFFFF) model_flush = 16'hFFFF;
    end
  end

  task automatic drive_cycle();
    rst       = rst_req;
    imem_gnt  = ($urandom_range(99) < gnt_pct);
    out_ready = ($urandom_range(99) < ready_pct);
    if (force_redir) begin
      redir_valid = 1'b1;
      redir_pc    = force_pc;
      force_redir = 1'b0;
    end else begin
      redir_valid = (!rst_req) && ($urandom_range(99) < redir_pct);
      redir_pc    = ADDR_W'($urandom);
    end
    if (!rst_req && memq.size() != 0 && $urandom_range(99) < rvalid_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_cycle();
    end
  endtask

  task automatic knobs(input int g, input int rd, input int rv, input int rr);
    gnt_pct    = g;
    ready_pct  = rd;
    rvalid_pct = rv;
    redir_pct  = rr;
  endtask

  initial begin
    rst         = 1'b1;
    rst_req     = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    out_ready   = 1'b0;
    knobs(100, 100, 100, 0);
    run(3);
    rst_req = 1'b0;
    // Full-rate streaming from reset.
    run(40);
    // Decode stalled: credits must cap outstanding work at DEPTH, then release.
    knobs(100, 0, 100, 0);
    run(20);
    knobs(100, 100, 100, 0);
    run(20);
    // PC wrap at the top of the address space.
    force_pc    = 7'd126;
    force_redir = 1'b1;
    run(20);
    // Redirects against outstanding requests and queued words.
    knobs(100, 70, 50, 10);
    run(600);
    // Stall followed by a redirect with work queued and in flight.
    knobs(100, 0, 100, 0);
    run(8);
    force_pc    = 7'd40;
    force_redir = 1'b1;
    knobs(100, 100, 100, 0);
    run(20);
    // Reset in the middle of traffic, then a mixed random phase.
    knobs(70, 60, 60, 5);
    run(50);
    rst_req = 1'b1;
    run(1);
    rst_req = 1'b0;
    run(1000);
    knobs(0, 100, 100, 0);
    run(30);
    @(negedge clk);
    #1;
    check("stream_progress", 64'(pops > 200), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
